// File: rtl/ram_dual_port_sweep.sv
// Dual-port RAM (one read-modify-write port, one registered read port) with a
// zeroing sweep engine that can be requested at run time or on reset release.
module ram_dual_port_sweep #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int BYPASS         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [1:0]            wr_op,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rd_valid,
  input  logic                  clear_rq,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ONE_D  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO_D = {DATA_WIDTH{1'b0}};

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    start_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    busy_s;
  logic                    wr_acc_s;
  logic [DATA_WIDTH-1:0]   cur_s;
  logic [DATA_WIDTH-1:0]   wr_val_s;
  logic [DATA_WIDTH-1:0]   dout_d;
  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_wa_s;
  logic [DATA_WIDTH-1:0]   mem_wd_s;

  assign busy_s   = (state_q == SWEEP);
  assign wr_acc_s = wr_en && !busy_s && (wr_op != 2'b11);
  assign cur_s    = mem_q[addr_in];

  // Value the write port would store this cycle (modulo arithmetic wraps naturally).
  always_comb begin
    wr_val_s = cur_s;
    case (wr_op)
      2'b00:   wr_val_s = dataIn;
      2'b01:   wr_val_s = cur_s + ONE_D;
      2'b10:   wr_val_s = cur_s - ONE_D;
      default: wr_val_s = cur_s;
    endcase
  end

  // Read data selection: zero during a sweep, optional write-through forwarding.
  always_comb begin
    dout_d = mem_q[addr_out];
    if (busy_s) begin
      dout_d = ZERO_D;
    end else if ((BYPASS != 0) && wr_acc_s && (addr_in == addr_out)) begin
      dout_d = wr_val_s;
    end else begin
      dout_d = mem_q[addr_out];
    end
  end

  // The sweep owns the array write port while busy.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = addr_in;
    mem_wd_s = wr_val_s;
    if (busy_s) begin
      mem_we_s = 1'b1;
      mem_wa_s = cnt_q;
      mem_wd_s = ZERO_D;
    end else begin
      mem_we_s = wr_acc_s;
    end
  end

  // Storage array; deliberately not reset so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_wa_s] <= mem_wd_s;
    end
  end

  // Sweep controller; start_q injects one clear request on reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= {ADDR_WIDTH{1'b0}};
      start_q <= (CLEAR_ON_RESET != 0);
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_rq || start_q) begin
            state_q <= SWEEP;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
          end
        end
        SWEEP: begin
          cnt_q <= cnt_q + ONE_A;
          if (cnt_q == LAST_A) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Registered read port; dataOut holds when no read is requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q     <= ZERO_D;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      dout_q     <= dout_d;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign busy     = busy_s;
  assign wr_ready = !busy_s;
  assign dataOut  = dout_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dual_port_sweep.sv
// Bench for ram_dual_port_sweep: two instances (old-value / CLEAR_ON_RESET=1 and
// new-value / CLEAR_ON_RESET=0) share stimulus and are checked against array models.
module tb_ram_dual_port_sweep;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en, rd_en, clear_rq;
  logic [1:0] wr_op;
  logic [3:0] addr_in, addr_out;
  logic [7:0] din;
  logic       w0, v0, b0, w1, v1, b1;
  logic [7:0] d0, d1;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m0 [16];
  logic [7:0] m1 [16];
  logic [7:0] h0, h1;

  always #5 clk = ~clk;

  ram_dual_port_sweep #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .BYPASS(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_op(wr_op), .addr_in(addr_in),
    .dataIn(din), .wr_ready(w0), .rd_en(rd_en), .addr_out(addr_out), .dataOut(d0),
    .rd_valid(v0), .clear_rq(clear_rq), .busy(b0));

  ram_dual_port_sweep #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .BYPASS(1), .CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_op(wr_op), .addr_in(addr_in),
    .dataIn(din), .wr_ready(w1), .rd_en(rd_en), .addr_out(addr_out), .dataOut(d1),
    .rd_valid(v1), .clear_rq(clear_rq), .busy(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 1'b0; rd_en = 1'b0; clear_rq = 1'b0;
    wr_op = 2'b11; addr_in = 4'd0; addr_out = 4'd0; din = 8'h00;
  endtask

  function automatic logic [7:0] apply(input logic [1:0] op, input logic [7:0] cur, input logic [7:0] d);
    case (op)
      2'b00:   return d;
      2'b01:   return cur + 8'd1;
      2'b10:   return cur - 8'd1;
      default: return cur;
    endcase
  endfunction

  task automatic write(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_op = op; addr_in = a; din = d;
    tick();
    m0[a] = apply(op, m0[a], d);
    m1[a] = apply(op, m1[a], d);
    idle_in();
  endtask

  task automatic read(input string tag, input logic [3:0] a);
    rd_en = 1'b1; addr_out = a;
    tick();
    chk({tag, "_valid0"}, v0, 1'b1);
    chk({tag, "_valid1"}, v1, 1'b1);
    chk({tag, "_data0"}, d0, m0[a]);
    chk({tag, "_data1"}, d1, m1[a]);
    h0 = m0[a]; h1 = m1[a];
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n0, n1;
    logic acc;
    logic [7:0] nv0, nv1, e0, e1;

    idle_in();
    reset_n = 1'b0;
    #12;
    chk("rst_busy0", b0, 1'b0);
    chk("rst_ready0", w0, 1'b1);
    chk("rst_valid0", v0, 1'b0);
    chk("rst_data0", d0, 8'h00);
    chk("rst_busy1", b1, 1'b0);
    chk("rst_data1", d1, 8'h00);

    // Release reset: dut0 auto-sweeps, dut1 is swept by an explicit request.
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_rq = 1'b1;
    tick();
    clear_rq = 1'b0;
    chk("sweep_ready0", w0, 1'b0);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40; k++) begin
      if (b0) n0++;
      if (b1) n1++;
      tick();
    end
    chk("init_busy_cycles0", n0, 16);
    chk("init_busy_cycles1", n1, 16);
    for (int i = 0; i < 16; i++) begin m0[i] = 8'h00; m1[i] = 8'h00; end
    for (int i = 0; i < 16; i++) read("init_clear", 4'(i));
    tick();
    chk("hold_valid0", v0, 1'b0);
    chk("hold_data0", d0, h0);

    // Wrap-around of increment and decrement.
    write(2'b00, 4'd3, 8'hFF);
    write(2'b01, 4'd3, 8'h00);
    read("inc_wrap", 4'd3);
    chk("inc_wrap_const", d0, 8'h00);
    write(2'b10, 4'd5, 8'h00);
    read("dec_wrap", 4'd5);
    chk("dec_wrap_const", d1, 8'hFF);
    write(2'b11, 4'd5, 8'h42);
    read("noop", 4'd5);

    // Same-cycle read and store: old value vs forwarded value.
    write(2'b00, 4'd7, 8'h11);
    wr_en = 1'b1; wr_op = 2'b00; addr_in = 4'd7; din = 8'h5A;
    rd_en = 1'b1; addr_out = 4'd7;
    tick();
    chk("rdw_old0", d0, 8'h11);
    chk("rdw_new1", d1, 8'h5A);
    m0[7] = 8'h5A; m1[7] = 8'h5A; h0 = 8'h11; h1 = 8'h5A;
    idle_in();

    // Randomized traffic against the array models.
    for (int k = 0; k < 200; k++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_op = 2'($urandom_range(0, 3));
      addr_in = 4'($urandom_range(0, 15));
      din = 8'($urandom);
      rd_en = 1'($urandom_range(0, 1));
      addr_out = ($urandom_range(0, 3) == 0) ? addr_in : 4'($urandom_range(0, 15));
      acc = wr_en && (wr_op != 2'b11);
      nv0 = apply(wr_op, m0[addr_in], din);
      nv1 = apply(wr_op, m1[addr_in], din);
      e0 = rd_en ? m0[addr_out] : h0;
      e1 = rd_en ? ((acc && addr_in == addr_out) ? nv1 : m1[addr_out]) : h1;
      tick();
      chk("rand_valid0", v0, rd_en);
      chk("rand_data0", d0, e0);
      chk("rand_data1", d1, e1);
      h0 = e0; h1 = e1;
      if (acc) begin m0[addr_in] = nv0; m1[addr_in] = nv1; end
    end
    idle_in();

    // Run-time sweep with a dropped write, a busy read and a repeated request.
    write(2'b00, 4'd15, 8'h77);
    clear_rq = 1'b1;
    tick();
    clear_rq = 1'b0;
    n0 = 0;
    for (int k = 0; k < 40; k++) begin
      if (b0) n0++;
      if (k == 3) begin
        chk("busy_ready0", w0, 1'b0);
        chk("busy_ready1", w1, 1'b0);
      end
      if (k == 5) begin wr_en = 1'b1; wr_op = 2'b00; addr_in = 4'd0; din = 8'h22; end
      if (k == 6) begin rd_en = 1'b1; addr_out = 4'd15; end
      if (k == 8) clear_rq = 1'b1;
      tick();
      if (k == 6) begin
        chk("busy_read_valid1", v1, 1'b1);
        chk("busy_read_data0", d0, 8'h00);
        chk("busy_read_data1", d1, 8'h00);
      end
      idle_in();
    end
    chk("rt_busy_cycles0", n0, 16);
    for (int i = 0; i < 16; i++) begin m0[i] = 8'h00; m1[i] = 8'h00; end
    for (int i = 0; i < 16; i++) read("rt_clear", 4'(i));

    // Reset in the middle of a sweep leaves a partially cleared array.
    for (int i = 0; i < 16; i++) write(2'b00, 4'(i), 8'hAA);
    clear_rq = 1'b1;
    tick();
    clear_rq = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_en = (k == 7);
      tick();
    end
    chk("mid_busy1", b1, 1'b1);
    chk("mid_valid1", v1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_busy1", b1, 1'b0);
    chk("async_ready1", w1, 1'b1);
    chk("async_valid1", v1, 1'b0);
    chk("async_data1", d1, 8'h00);
    chk("async_busy0", b0, 1'b0);
    idle_in();
    @(posedge clk); #2;
    reset_n = 1'b1;
    tick();
    chk("rel_busy0", b0, 1'b1);
    chk("rel_busy1", b1, 1'b0);
    for (int k = 0; k < 16; k++) tick();
    chk("rel_done0", b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      m0[i] = 8'h00;
      m1[i] = (i < 8) ? 8'h00 : 8'hAA;
    end
    for (int i = 0; i < 16; i++) read("partial", 4'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_dual_port_sweep.md
RAM_DUAL_PORT_SWEEP -- requirements
Module: ram_dual_port_sweep

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of one memory cell.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9; DEPTH = 2**ADDR_WIDTH cells.
REQ-003 The block SHALL have parameter BYPASS, default 0; 1 = read-during-write returns the new value, 0 = the old value.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1; 1 = an automatic clear sweep starts on reset release.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write-port request.
REQ-008 The block SHALL have port wr_op, input, 2 bits: 00 store, 01 increment, 10 decrement, 11 no-op.
REQ-009 The block SHALL have port addr_in, input, ADDR_WIDTH bits: write-port address.
REQ-010 The block SHALL have port dataIn, input, DATA_WIDTH bits: store data.
REQ-011 The block SHALL have port wr_ready, output, 1 bit: high when write requests are accepted.
REQ-012 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-013 The block SHALL have port addr_out, input, ADDR_WIDTH bits: read address.
REQ-014 The block SHALL have port dataOut, output, DATA_WIDTH bits: registered read data.
REQ-015 The block SHALL have port rd_valid, output, 1 bit: dataOut is valid this cycle.
REQ-016 The block SHALL have port clear_rq, input, 1 bit: request a zeroing sweep.
REQ-017 The block SHALL have port busy, output, 1 bit: high while a sweep runs.

Function
REQ-018 The controller SHALL have two states: IDLE and SWEEP; busy = (state == SWEEP), wr_ready = !busy.
REQ-019 In IDLE, clear_rq = 1 SHALL load sweep counter 0 and enter SWEEP on the next edge.
REQ-020 In SWEEP, each cycle SHALL write 0 to cell[counter] and increment counter; after writing cell DEPTH-1, the next state SHALL be IDLE (busy high exactly DEPTH cycles).
REQ-021 clear_rq during SWEEP SHALL be ignored; the sweep neither restarts nor extends.
REQ-022 wr_en while busy SHALL be dropped with no cell change.
REQ-023 Accepted store SHALL write dataIn to cell[addr_in] at the clock edge.
REQ-024 Accepted increment/decrement SHALL write cell[addr_in] +/- 1 modulo 2**DATA_WIDTH (all-ones + 1 = 0, 0 - 1 = all-ones) in one cycle.
REQ-025 wr_op = 11 SHALL leave memory unchanged.
REQ-026 rd_en = 1 SHALL produce dataOut and rd_valid = 1 one cycle later; rd_en = 0 SHALL make rd_valid = 0 next cycle with dataOut held.
REQ-027 Reads accepted while busy SHALL return 0.
REQ-028 In IDLE, a read and an accepted write to the same address in the same cycle SHALL return the post-write value when BYPASS = 1, else the pre-write value.
REQ-029 Read and write to different addresses SHALL be independent in the same cycle.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, sweep counter 0, dataOut 0, rd_valid 0, busy 0, wr_ready 1, independent of clk.
REQ-031 Memory contents SHALL NOT be modified by reset itself; a sweep interrupted by reset SHALL leave cells in their partially-cleared state.
REQ-032 With CLEAR_ON_RESET = 1, the first edge after reset_n rises SHALL enter SWEEP as if clear_rq were asserted; with 0, the block SHALL stay in IDLE.

Verification
REQ-033 Reset release, CLEAR_ON_RESET = 1, ADDR_WIDTH = 4 -> busy high 16 cycles, then reads of all 16 cells return 0 with rd_valid one cycle after rd_en.
REQ-034 Store 0xFF at addr 3, increment addr 3, read addr 3 -> dataOut 0x00; decrement addr 5 (holding 0) -> read returns 0xFF.
REQ-035 Same-cycle store 0x5A and read at addr 7 (cell holds 0x11) -> dataOut 0x5A with BYPASS = 1, 0x11 with BYPASS = 0.
REQ-036 clear_rq in IDLE, then wr_en store 0x22 during SWEEP, and a second clear_rq mid-sweep -> wr_ready 0, write lost, busy still exactly DEPTH cycles, all cells 0.
REQ-037 reset_n asserted mid-sweep at counter 8 (cells pre-filled 0xAA, CLEAR_ON_RESET = 0) -> outputs reset at once, cells 0..7 = 0, 8..15 = 0xAA, state IDLE.
